// File: rtl/adder_tree_ctrl_if.sv
// ----------------------------------------------------------------------------
// adder_tree_ctrl_if
// Groups the job-control, operand handshake, adder-control and result
// handshake signals of adder_tree_ctrl into one bundle.
//
// Signals:
//   start, abort           job begin / job cancel
//   cfg_len, cfg_groups    operands per group, groups per job (CNT_W bits)
//   in_valid, in_ready     upstream operand handshake
//   acc_gate               adder operand mux select (1 = pass operand)
//   acc_accum              adder accum control (0 = load, 1 = accumulate)
//   acc_out_en             adder output enable
//   out_valid, out_ready   finished group sum handshake
//   busy, done, cfg_err    job status
//
// Modports:
//   master  the side that issues jobs, supplies operands and consumes sums
//   slave   the controller itself
// ----------------------------------------------------------------------------
interface adder_tree_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] cfg_len;
    logic [CNT_W-1:0] cfg_groups;
    logic             in_valid;
    logic             in_ready;
    logic             acc_gate;
    logic             acc_accum;
    logic             acc_out_en;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic             cfg_err;

    modport master (
        output start, abort, cfg_len, cfg_groups, in_valid, out_ready,
        input  in_ready, acc_gate, acc_accum, acc_out_en, out_valid,
               busy, done, cfg_err
    );

    modport slave (
        input  start, abort, cfg_len, cfg_groups, in_valid, out_ready,
        output in_ready, acc_gate, acc_accum, acc_out_en, out_valid,
               busy, done, cfg_err
    );
endinterface

// File: rtl/adder_tree_ctrl.sv
// ----------------------------------------------------------------------------
// adder_tree_ctrl
// Sequencing controller for an external accumulating adder (one-cycle
// register latency). A job is cfg_groups groups of cfg_len operands; each
// group's sum is presented with out_valid and held until out_ready. The first
// operand of the next group may be accepted in the same cycle the previous
// sum is consumed, so back-to-back groups run without a bubble.
//
// Ports:
//   clk     single clock, rising edge
//   reset   synchronous active-high reset
//   bus     adder_tree_ctrl_if.slave (job control, operand/result
//           handshakes, adder control, status)
// ----------------------------------------------------------------------------
module adder_tree_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    adder_tree_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] op_cnt;
    logic [CNT_W-1:0] grp_cnt;
    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] groups_q;
    logic             busy_q;
    logic             out_valid_q;
    logic             done_q;
    logic             cfg_err_q;

    logic             in_ready_c;
    logic             accept;
    logic             last_op;
    logic             last_group;

    // Handshake decisions that must react in the same cycle (operand accept
    // during HOLD, abort/reset suppression) are combinational.
    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        last_op    = (op_cnt == len_q - CNT_W'(1));
        last_group = (grp_cnt == groups_q - CNT_W'(1));
        in_ready_c = 1'b0;
        if (!reset && !bus.abort) begin
            case (state)
                ACCUM:   in_ready_c = 1'b1;
                // A sum being consumed frees the adder for the next group,
                // unless this was the final group of the job.
                HOLD:    in_ready_c = bus.out_ready && !last_group;
                default: in_ready_c = 1'b0;
            endcase
        end
        accept = bus.in_valid && in_ready_c;
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.acc_gate   = accept;
    // Load (accum=0) only on the first operand of a group; every other cycle
    // accumulates a forced-zero operand, which holds the adder register.
    assign bus.acc_accum  = !(accept && (op_cnt == '0));
    assign bus.out_valid  = out_valid_q;
    assign bus.acc_out_en = out_valid_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.cfg_err    = cfg_err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and update order inside the block is irrelevant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op_cnt      <= '0;
            grp_cnt     <= '0;
            len_q       <= '0;
            groups_q    <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            if (bus.abort) begin
                state       <= IDLE;
                op_cnt      <= '0;
                grp_cnt     <= '0;
                busy_q      <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            if ((bus.cfg_len != '0) && (bus.cfg_groups != '0)) begin
                                len_q    <= bus.cfg_len;
                                groups_q <= bus.cfg_groups;
                                op_cnt   <= '0;
                                grp_cnt  <= '0;
                                busy_q   <= 1'b1;
                                state    <= ACCUM;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end

                    ACCUM: begin
                        if (accept) begin
                            if (last_op) begin
                                op_cnt      <= '0;
                                out_valid_q <= 1'b1;
                                state       <= HOLD;
                            end else begin
                                op_cnt <= op_cnt + CNT_W'(1);
                            end
                        end
                    end

                    HOLD: begin
                        if (bus.out_ready) begin
                            if (last_group) begin
                                grp_cnt     <= '0;
                                busy_q      <= 1'b0;
                                out_valid_q <= 1'b0;
                                done_q      <= 1'b1;
                                state       <= IDLE;
                            end else begin
                                grp_cnt <= grp_cnt + CNT_W'(1);
                                // op_cnt is zero here, so last_op means len==1:
                                // the accepted operand is already a full group.
                                if (accept && last_op) begin
                                    state <= HOLD;
                                end else begin
                                    if (accept) begin
                                        op_cnt <= op_cnt + CNT_W'(1);
                                    end
                                    out_valid_q <= 1'b0;
                                    state       <= ACCUM;
                                end
                            end
                        end
                    end

                    default: begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/adder_tree_ctrl.md
ADDER_TREE_CTRL -- requirements
Module: adder_tree_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of operand-count and group-count fields.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  begin a job; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  synchronous job cancel.
REQ-006 SHALL have port cfg_len  input  CNT_W  operands per accumulation group; latched on accepted start.
REQ-007 SHALL have port cfg_groups  input  CNT_W  groups per job; latched on accepted start.
REQ-008 SHALL have port in_valid  input  1  upstream operand valid.
REQ-009 SHALL have port in_ready  output  1  controller accepts operand this cycle.
REQ-010 SHALL have port acc_gate  output  1  adder operand mux select: 1 = pass operand, 0 = force in_a to zero.
REQ-011 SHALL have port acc_accum  output  1  drives adder accum.
REQ-012 SHALL have port acc_out_en  output  1  drives adder out_en.
REQ-013 SHALL have port out_valid  output  1  adder out_s holds a finished group sum.
REQ-014 SHALL have port out_ready  input  1  downstream consumes sum.
REQ-015 SHALL have ports busy  output  1 (job active), done  output  1 (one-cycle job-complete pulse), cfg_err  output  1 (one-cycle bad-config pulse).

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-017 IDLE: start=1 with cfg_len!=0 and cfg_groups!=0 SHALL latch both, clear op_cnt and grp_cnt, go to ACCUM; start with either field zero SHALL pulse cfg_err next cycle and stay IDLE.
REQ-018 IDLE: in_ready=0, acc_gate=0, acc_accum=1, out_valid=0, acc_out_en=0, busy=0.
REQ-019 ACCUM: in_ready=1; an operand is accepted when in_valid&in_ready; acc_gate SHALL equal the accept condition (combinational).
REQ-020 acc_accum SHALL be 0 on the accepting cycle of the first operand of a group (op_cnt==0), 1 in all other cycles, so non-accept cycles hold the adder register (in_a forced 0, accum=1).
REQ-021 Each accept SHALL increment op_cnt; the accept with op_cnt==len-1 SHALL clear op_cnt and move to HOLD.
REQ-022 Latency: last operand accepted in cycle t SHALL give out_valid=1 and acc_out_en=1 in cycle t+1 (adder register latency 1).
REQ-023 HOLD: out_valid=1, acc_out_en=1; without out_ready SHALL stay, in_ready=0, acc_gate=0, acc_accum=1 (sum stable).
REQ-024 HOLD with out_ready=1: grp_cnt SHALL increment; if grp_cnt==groups-1 SHALL go to IDLE with done=1 next cycle and in_ready=0; otherwise in_ready=1 in that same cycle and, if in_valid, the first operand of the next group SHALL be accepted with acc_accum=0 (zero-bubble); next state ACCUM, or HOLD if len==1 and operand accepted.
REQ-025 cfg_len==1 SHALL produce one out_valid per accepted operand with sum equal to that operand.
REQ-026 busy SHALL be 1 in ACCUM and HOLD.
REQ-027 abort=1 in any state SHALL force IDLE next cycle, clear counters, no done pulse; abort has priority over start and handshakes in the same cycle; in_ready and acc_gate SHALL be 0 in the abort cycle.
REQ-028 Counters SHALL compare at full CNT_W width; len and groups up to 2^CNT_W-1 without wrap.
REQ-029 cfg_* changes while busy SHALL have no effect.

Reset
REQ-030 reset=1 at a rising edge SHALL force IDLE, op_cnt=0, grp_cnt=0, latched config 0, done=0, cfg_err=0; outputs then per REQ-018; reset mid-job discards partial sum and has priority over abort and start.

Verification
REQ-031 len=4, groups=1, operands 1,2,3,4 back-to-back, out_ready=1 -> accum pattern 0,1,1,1; out_valid one cycle after 4th accept, sum 10; done pulse next cycle.
REQ-032 len=3, groups=2, out_ready low 5 cycles on first sum -> in_ready=0 and sum stable 5 cycles; after out_ready, second group sums correctly, no operand lost.
REQ-033 len=2, groups=3, in_valid always 1, out_ready always 1 -> first operand of groups 2 and 3 accepted in HOLD cycle with accum=0; three sums, no bubble.
REQ-034 len=1, groups=4, operands 5,6,7,8 -> out_valid sums 5,6,7,8, each 1 cycle after accept.
REQ-035 start with cfg_len=0 -> cfg_err pulse, busy stays 0; abort mid-group then new start (len=2, operands 9,1) -> sum 10, no residue from aborted group.
REQ-036 reset asserted in HOLD -> next cycle all outputs per REQ-018, out_valid=0, no done.
